// File: rtl/accel_mem_pkg.sv
// accel_mem_pkg: shared widths, requester IDs, key window and lock FSM encodings
package accel_mem_pkg;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 19;
    localparam logic REQ_FFT = 1'b0;
    localparam logic REQ_CRYPTO = 1'b1;
    localparam logic [1:0] KEY_WIN = 2'b11;
    typedef enum logic {
        LK_IDLE   = 1'b0,
        LK_LOCKED = 1'b1
    } lock_state_e;
endpackage

// File: rtl/accel_rr_lock_arb.sv
// accel_rr_lock_arb: two-way round-robin arbiter with bounded burst lock
module accel_rr_lock_arb
    import accel_mem_pkg::*;
#(
    parameter int LOCK_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_active,
    input  logic [1:0] valid,
    input  logic [1:0] lock,
    output logic [1:0] grant
);
    localparam int LC_W = $clog2(LOCK_MAX + 1);
    lock_state_e state, state_n;
    logic ptr, ptr_n, owner, owner_n, win, any;
    logic [LC_W-1:0] lock_cnt, lock_cnt_n;

    always_comb begin
        win = (state == LK_LOCKED) ? owner : (valid[0] & valid[1]) ? ptr : valid[REQ_CRYPTO];
        any = !cpu_active && valid[win];
        grant = any ? (2'b01 << win) : 2'b00;
        state_n = state;
        ptr_n = ptr;
        owner_n = owner;
        lock_cnt_n = lock_cnt;
        // lock_cnt is 0 in IDLE, so the same bound covers entering and extending a lock
        if (any) begin
            if (lock[win] && int'(lock_cnt) + 1 < LOCK_MAX) begin
                state_n = LK_LOCKED;
                owner_n = win;
                lock_cnt_n = lock_cnt + 1'b1;
            end else begin
                state_n = LK_IDLE;
                ptr_n = ~win;
                lock_cnt_n = '0;
            end
        end else if (state == LK_LOCKED && !valid[owner]) begin
            state_n = LK_IDLE;
            ptr_n = ~owner;
            lock_cnt_n = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LK_IDLE;
            ptr <= REQ_FFT;
            owner <= REQ_FFT;
            lock_cnt <= '0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            owner <= owner_n;
            lock_cnt <= lock_cnt_n;
        end
    end
endmodule

// File: rtl/accel_mem_responder.sv
// accel_mem_responder: shares the data-memory port between FFT and crypto units behind the MEM stage
module accel_mem_responder #(
    parameter int ADDR_W   = accel_mem_pkg::ADDR_W,
    parameter int DATA_W   = accel_mem_pkg::DATA_W,
    parameter int LOCK_MAX = 8,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_active,
    input  logic              fft_req_valid,
    output logic              fft_req_ready,
    input  logic              fft_req_we,
    input  logic              fft_req_lock,
    input  logic [ADDR_W-1:0] fft_req_addr,
    input  logic [DATA_W-1:0] fft_req_wdata,
    output logic              fft_rsp_valid,
    output logic [DATA_W-1:0] fft_rsp_data,
    output logic              fft_rsp_err,
    input  logic              crypto_req_valid,
    output logic              crypto_req_ready,
    input  logic              crypto_req_we,
    input  logic              crypto_req_lock,
    input  logic [ADDR_W-1:0] crypto_req_addr,
    input  logic [DATA_W-1:0] crypto_req_wdata,
    output logic              crypto_rsp_valid,
    output logic [DATA_W-1:0] crypto_rsp_data,
    output logic              crypto_rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  fft_stall_cnt,
    output logic [CNT_W-1:0]  crypto_stall_cnt
);
    import accel_mem_pkg::*;
    logic [1:0] grant;
    logic sel, sel_we, key, acc;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic rsp_v, rsp_id, rsp_rd, rsp_err;

    accel_rr_lock_arb #(.LOCK_MAX(LOCK_MAX)) u_arb (
        .clk(clk),
        .rst(rst),
        .cpu_active(cpu_active),
        .valid({crypto_req_valid, fft_req_valid}),
        .lock({crypto_req_lock, fft_req_lock}),
        .grant(grant)
    );

    assign fft_req_ready = grant[REQ_FFT];
    assign crypto_req_ready = grant[REQ_CRYPTO];

    // key-window beats complete the handshake but never reach the memory
    always_comb begin
        sel = grant[REQ_CRYPTO];
        sel_we = sel ? crypto_req_we : fft_req_we;
        sel_addr = sel ? crypto_req_addr : fft_req_addr;
        sel_wdata = sel ? crypto_req_wdata : fft_req_wdata;
        key = sel_addr[ADDR_W-1 -: 2] == KEY_WIN;
        acc = |grant & ~key;
        mem_en = acc;
        mem_we = acc & sel_we;
        mem_addr = acc ? sel_addr : '0;
        mem_wdata = (acc & sel_we) ? sel_wdata : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_v <= 1'b0;
            rsp_id <= REQ_FFT;
            rsp_rd <= 1'b0;
            rsp_err <= 1'b0;
        end else begin
            rsp_v <= |grant;
            rsp_id <= sel;
            rsp_rd <= acc & ~sel_we;
            rsp_err <= |grant & key;
        end
    end

    assign fft_rsp_valid = rsp_v & (rsp_id == REQ_FFT);
    assign crypto_rsp_valid = rsp_v & (rsp_id == REQ_CRYPTO);
    assign fft_rsp_err = fft_rsp_valid & rsp_err;
    assign crypto_rsp_err = crypto_rsp_valid & rsp_err;
    assign fft_rsp_data = (fft_rsp_valid & rsp_rd) ? mem_rdata : '0;
    assign crypto_rsp_data = (crypto_rsp_valid & rsp_rd) ? mem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fft_stall_cnt <= '0;
            crypto_stall_cnt <= '0;
        end else begin
            if (fft_req_valid & ~fft_req_ready & ~&fft_stall_cnt)
                fft_stall_cnt <= fft_stall_cnt + 1'b1;
            if (crypto_req_valid & ~crypto_req_ready & ~&crypto_stall_cnt)
                crypto_stall_cnt <= crypto_stall_cnt + 1'b1;
        end
    end
endmodule
